// File: rtl/spart_tx_if.sv
// spart_tx_if: bus between the SPART bus interface / baud generator and the transmitter.
//   baud_tick : one-clk enable pulse at OVERSAMPLE x baud rate
//   tx_wr_en  : write strobe, loads tx_data into the holding buffer when tbr=1
//   tx_data   : byte to transmit
//   tbr       : transmit buffer ready (holding buffer empty)
//   tx_busy   : frame in progress
//   txd       : serial line, idles high
interface spart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 tx_wr_en;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tbr;
    logic                 tx_busy;
    logic                 txd;

    // Driver side: bus interface and baud generator
    modport master (
        output baud_tick,
        output tx_wr_en,
        output tx_data,
        input  tbr,
        input  tx_busy,
        input  txd
    );

    // Transmitter side
    modport slave (
        input  baud_tick,
        input  tx_wr_en,
        input  tx_data,
        output tbr,
        output tx_busy,
        output txd
    );
endinterface

// File: rtl/spart_tx.sv
// spart_tx: 8N1 asynchronous serial transmitter with a one-byte holding buffer.
//   clk : system clock
//   rst : asynchronous, active-high reset; aborts any frame and drops queued bytes
//   bus : spart_tx_if.slave (baud_tick, tx_wr_en, tx_data in; tbr, tx_busy, txd out)
// Each bit lasts OVERSAMPLE baud_ticks; data goes out LSB first.
module spart_tx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    spart_tx_if.slave   bus
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_tbr;
    logic                 r_busy;
    logic                 r_txd;

    logic                 w_bit_end;
    logic                 w_hold_full;
    logic                 w_load;
    logic                 w_accept;
    logic [DATA_BITS-1:0] w_shift_next;

    // Current bit has received its last baud_tick on this edge
    assign w_bit_end    = bus.baud_tick && (r_tick_cnt == TICK_LAST);
    assign w_hold_full  = ~r_tbr;
    // Hold-to-shifter transfer: from IDLE at once, or straight out of a finished stop bit
    assign w_load       = w_hold_full &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    // w_load implies hold is full, so a write can never collide with a transfer
    assign w_accept     = bus.tx_wr_en && r_tbr;
    assign w_shift_next = r_shift >> 1;

    // Transmit state machine, holding buffer and bit timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tbr      <= 1'b1;
            r_busy     <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            // Holding buffer
            if (w_load) begin
                r_tbr <= 1'b1;
            end else if (w_accept) begin
                r_hold <= bus.tx_data;
                r_tbr  <= 1'b0;
            end

            // Oversample counter; parked at zero while idle
            if (w_load) begin
                r_tick_cnt <= '0;
            end else if ((r_state != S_IDLE) && bus.baud_tick) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state   <= S_START;
                        r_shift   <= r_hold;
                        r_bit_cnt <= '0;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                        r_txd     <= r_shift[0];
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_txd     <= w_shift_next[0];
                        end
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_load) begin
                            // Back-to-back frame: no idle gap on the line
                            r_state   <= S_START;
                            r_shift   <= r_hold;
                            r_bit_cnt <= '0;
                            r_txd     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tbr     = r_tbr;
    assign bus.tx_busy = r_busy;
    assign bus.txd     = r_txd;

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed and randomized bench for spart_tx against a frame-level
// reference model (expected line level = frame bit selected by ticks elapsed / OVERSAMPLE).
module tb_spart_tx;

    localparam int OS    = 16;
    localparam int FBITS = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spart_tx_if #(.DATA_BITS(8)) bus ();

    spart_tx #(
        .OVERSAMPLE(OS),
        .DATA_BITS (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus control
    int cyc         = 0;
    int tick_period = 4;
    bit tick_stall  = 1'b0;
    bit tick_rand   = 1'b0;

    // Reference model: one frame = {stop, data, start}, indexed by ticks elapsed
    bit         m_busy      = 1'b0;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold      = 8'h00;
    logic [9:0] m_frame     = 10'h3FF;
    int         m_ticks     = 0;

    function automatic logic exp_txd();
        if (!m_busy) return 1'b1;
        return m_frame[m_ticks / OS];
    endfunction

    task automatic model_edge(input bit r, input bit wr, input logic [7:0] d, input bit tk);
        bit done;
        bit ok;
        if (r) begin
            m_busy      = 1'b0;
            m_hold_full = 1'b0;
            m_ticks     = 0;
            return;
        end
        done = m_busy && tk && (m_ticks == FBITS * OS - 1);
        ok   = wr && !m_hold_full;
        if (m_busy && tk) m_ticks++;
        if (m_hold_full && (!m_busy || done)) begin
            m_frame     = {1'b1, m_hold, 1'b0};
            m_ticks     = 0;
            m_busy      = 1'b1;
            m_hold_full = 1'b0;
        end else if (done) begin
            m_busy = 1'b0;
        end
        if (ok) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("txd",     bus.txd,     exp_txd());
        check("tbr",     bus.tbr,     !m_hold_full);
        check("tx_busy", bus.tx_busy, m_busy);
    endtask

    function automatic bit gen_tick();
        if (tick_stall) return 1'b0;
        if (tick_rand)  return ($urandom_range(0, 3) == 0);
        return (cyc % tick_period) == 0;
    endfunction

    // One clock: drive inputs, take the edge, advance the model, compare
    task automatic cycle(input bit wr, input logic [7:0] d);
        bit tk;
        tk = gen_tick();
        bus.baud_tick = tk;
        bus.tx_wr_en  = wr;
        bus.tx_data   = d;
        @(posedge clk);
        model_edge(rst, wr, d, tk);
        cyc++;
        #1;
        check_all();
        bus.tx_wr_en = 1'b0;
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((m_busy || m_hold_full) && n < budget) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=<%0d", tag, n, budget);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00);
    endtask

    initial begin
        int n;
        bit ok;
        rst           = 1'b1;
        bus.baud_tick = 1'b0;
        bus.tx_wr_en  = 1'b0;
        bus.tx_data   = 8'h00;

        // Reset and idle line
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        check("rst_txd",  bus.txd,     1'b1);
        check("rst_tbr",  bus.tbr,     1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);
        check("idle_txd",  bus.txd,     1'b1);
        check("idle_busy", bus.tx_busy, 1'b0);

        // Single byte 0xA5: write latency and start bit
        cycle(1'b1, 8'hA5);
        check("wr_tbr_low", bus.tbr, 1'b0);
        cycle(1'b0, 8'h00);
        check("start_txd",  bus.txd,     1'b0);
        check("start_tbr",  bus.tbr,     1'b1);
        check("start_busy", bus.tx_busy, 1'b1);
        run_idle(2000, "single");
        check("single_end_busy", bus.tx_busy, 1'b0);

        // Back-to-back 0x55 then 0x0F, second byte queued as soon as tbr returns
        cycle(1'b1, 8'h55);
        n = 0;
        while (m_hold_full && n < 10) begin cycle(1'b0, 8'h00); n++; end
        cycle(1'b1, 8'h0F);
        check("b2b_queued_tbr", bus.tbr, 1'b0);
        run_idle(4000, "b2b");

        // Overrun: three writes on consecutive cycles; the one meeting the transfer is dropped
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        cycle(1'b1, 8'h33);
        run_idle(4000, "overrun");

        // Reset in the middle of data bit 3 of 0xC3
        cycle(1'b1, 8'hC3);
        n = 0;
        while (!(m_busy && (m_ticks / OS) == 4 && (m_ticks % OS) == 5) && n < 2000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++;
            $error("FAIL midrst_reach: observed=%0d cycles expected=<2000", n);
        end
        rst = 1'b1;
        #1;
        model_edge(1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_txd",  bus.txd,     1'b1);
        check("midrst_tbr",  bus.tbr,     1'b1);
        check("midrst_busy", bus.tx_busy, 1'b0);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        #2;
        rst = 1'b0;
        cycle(1'b1, 8'h81);
        run_idle(2000, "after_rst");

        // Tick stall inside the start bit of 0xFF
        cycle(1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
        tick_stall = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 8'h00);
            if (bus.txd !== 1'b0) ok = 1'b0;
        end
        check("stall_txd_low", ok, 1'b1);
        check("stall_busy",    bus.tx_busy, 1'b1);
        tick_stall = 1'b0;
        run_idle(2000, "stall");

        // baud_tick held high: each bit lasts OVERSAMPLE clks
        tick_period = 1;
        cycle(1'b1, 8'($urandom));
        n = 0;
        while (m_hold_full && n < 10) begin cycle(1'b0, 8'h00); n++; end
        cycle(1'b1, 8'($urandom));
        run_idle(1000, "cont_tick");

        // Random ticks and random write attempts
        tick_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 39) == 0), 8'($urandom));
        end
        run_idle(20000, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
